ped_request_latch: RTL
======================

Name: ped_request_latch

Overview:
- Request side of the pedestrian request/acknowledge handshake into the traffic signal FSM; the controller is the consumer.
- Synchronises and debounces the raw pedestrian push-button.
- Converts each debounced press into a held `ped_req` level that stays high until the controller acknowledges it.
- A press arriving while a request is already being served is stored and re-issued, so no press is lost.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive clk cycles the synchronised button must differ from the debounced state before that state is accepted; legal range 2..255.
- CNT_W, 8: width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
- btn_raw  input  1  raw push-button, asynchronous to clk, bouncy, active-high.
- ped_ack  input  1  controller acknowledge, synchronous to clk, level.
- ped_req  output  1  registered pending-request level to the controller.
- press_pulse  output  1  registered one-cycle strobe per debounced press.
- btn_db  output  1  registered debounced button level.

Behaviour:
- Reset (reset=0, asynchronous): both synchroniser flops=0, debounce counter=0, btn_db=0, press_pulse=0, ped_req=0, rearm=0, FSM=IDLE.
  - Reset asserted mid-handshake drops ped_req immediately; any stored press is discarded.
- Synchroniser: two flops, btn_raw -> s1 -> s2.
- Debounce counter:
  - If s2==btn_db: counter <= 0.
  - Else if counter==DEBOUNCE_CYCLES-1: btn_db <= s2, counter <= 0.
  - Else: counter <= counter+1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles leaves btn_db unchanged. Release is debounced the same way.
- press_pulse: registered rising-edge detect of btn_db; high for exactly one cycle. Release produces no pulse.
- Latency: btn_raw high and stable before edge E0 gives:
  - btn_db=1 after edge E(N+1), where N=DEBOUNCE_CYCLES.
  - press_pulse=1 after E(N+2).
  - ped_req=1 after E(N+3).
- FSM states and transitions:
  - IDLE: ped_req=0. press_pulse -> PENDING.
  - PENDING: ped_req=1. ped_ack=1 -> SERVED.
    - Further presses in PENDING merge into the outstanding request.
    - Exception: a press_pulse in the same cycle as ped_ack sets rearm.
  - SERVED: ped_req=0. press_pulse sets rearm. When ped_ack=0:
    - rearm=1 -> PENDING, rearm <= 0.
    - rearm=0 -> IDLE.
    - A press_pulse in that same cycle also counts as a rearm.
- Handshake rules:
  - ped_req is never deasserted before ped_ack is seen.
  - ped_req is never reasserted while ped_ack is still high.
  - ped_ack arriving in IDLE is ignored.
- ped_req is a decoded, registered state bit: glitch-free, with no combinational path from any input.

Optional Feature:
- Macro: PED_REQ_COUNT_EN.
- Defined:
  - Adds output `req_count [7:0]`, reset 0.
  - Increments on each IDLE->PENDING or SERVED->PENDING transition.
  - Saturates at 255; does not wrap.
  - Merged presses are not counted.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 with btn_raw=1 and ped_ack=1 -> all outputs 0. Deassert with btn_raw=0 -> outputs stay 0 for 50 cycles.
- Clean press, DEBOUNCE_CYCLES=4: btn_raw 0->1 before edge E0 and held -> btn_db rises after E5, press_pulse high only during the cycle after E6, ped_req rises after E7. Apply ped_ack=1 -> ped_req falls on the next edge.
- Bounce rejection, DEBOUNCE_CYCLES=4: pulses of 1, 2 and 3 cycles on btn_raw separated by 3-cycle lows -> btn_db, press_pulse and ped_req stay 0 throughout.
- Merge and rearm:
  - Two presses while PENDING -> a single ack completes the request; ped_req stays 0 after ack drops.
  - One press while SERVED (ack held high) -> ped_req reasserts on the edge after ack falls.
- Simultaneous press and ack: press_pulse coincides with ped_ack in PENDING -> ped_req falls, then reasserts after ped_ack=0. Then assert reset mid-PENDING -> ped_req=0 asynchronously, no reissue after release.
- PED_REQ_COUNT_EN defined: 300 separate press/ack cycles -> req_count reads 255 and holds. Merged presses do not increment it.

Source files
------------

// File: rtl/ped_request_latch.sv
// Pedestrian push-button synchroniser/debouncer feeding a held request/acknowledge handshake.
// Optional PED_REQ_COUNT_EN adds a saturating count of issued requests on req_count.
module ped_request_latch #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       ped_ack,
  output logic       ped_req,
  output logic       press_pulse,
  output logic       btn_db
`ifdef PED_REQ_COUNT_EN
  ,
  output logic [7:0] req_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    SERVED  = 2'b10
  } state_t;

  logic             s1, s2;
  logic [CNT_W-1:0] db_cnt;
  logic             btn_db_prev;
  state_t           state, state_nxt;
  logic             rearm, rearm_nxt;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // State is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (s2 == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      btn_db <= s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_db_prev <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      btn_db_prev <= btn_db;
      press_pulse <= btn_db & ~btn_db_prev;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rearm <= 1'b0;
    end else begin
      state <= state_nxt;
      rearm <= rearm_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rearm_nxt = rearm;
    unique case (state)
      IDLE: begin
        if (press_pulse) state_nxt = PENDING;
      end
      PENDING: begin
        if (ped_ack) begin
          state_nxt = SERVED;
          // A press landing on the ack cycle belongs to the next request.
          if (press_pulse) rearm_nxt = 1'b1;
        end
      end
      SERVED: begin
        if (!ped_ack) begin
          state_nxt = (rearm || press_pulse) ? PENDING : IDLE;
          rearm_nxt = 1'b0;
        end else if (press_pulse) begin
          rearm_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        rearm_nxt = 1'b0;
      end
    endcase
  end

  // Only PENDING has bit 0 set, so every legal transition decodes glitch-free.
  assign ped_req = (state == PENDING);

`ifdef PED_REQ_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_count <= 8'd0;
    end else if ((state_nxt == PENDING) && (state != PENDING) && (req_count != 8'hFF)) begin
      req_count <= req_count + 8'd1;
    end
  end
`endif

endmodule
